// File: rtl/adder_share_arbiter.sv
// One ripple-carry adder shared round-robin by N_REQ requesters; result SETTLE_CYC+1 cycles after grant.
// A result is held until rsp_ready and no grant is issued while busy. ADDER_ARB_GRANT_CNT_EN adds grant_cnt.

module ripple_carry #(
  parameter int ANCHO = 64
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             cin,
  output logic [ANCHO:0]   s
);

  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    for (int i = 0; i < ANCHO; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    s[ANCHO] = carry;
  end

endmodule

module adder_share_arbiter #(
  parameter int ANCHO      = 64,
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ANCHO-1:0]     req_a,
  input  logic [N_REQ*ANCHO-1:0]     req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ANCHO:0]             rsp_sum,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
`ifdef ADDER_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]                grant_cnt
`endif
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ANCHO-1:0] op_a_q, op_a_d;
  logic [ANCHO-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ANCHO:0]   rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             gap_q, gap_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             grant;
  logic [ANCHO:0]   adder_s;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= N_REQ) k = k - N_REQ;
    return k[IDW-1:0];
  endfunction

  ripple_carry #(.ANCHO(ANCHO)) u_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .cin (1'b0),
    .s   (adder_s)
  );

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[wrap_idx(rr_ptr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  // gap_q holds off the grant for the first IDLE cycle after a response retires
  assign grant = (state_q == IDLE) && !gap_q && gnt_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    gap_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          op_a_d   = req_a[gnt_idx*ANCHO +: ANCHO];
          op_b_d   = req_b[gnt_idx*ANCHO +: ANCHO];
          id_d     = gnt_idx;
          rr_ptr_d = wrap_idx(gnt_idx, 1);
          cnt_d    = 4'(SETTLE_CYC - 1);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_sum_d   = adder_s;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          gap_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (grant && grant_cnt_q != 16'hFFFF) grant_cnt_d = grant_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) grant_cnt_q <= '0;
    else     grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one Ripple_Carry adder instance among N_REQ requesters.
- Round-robin arbitration, valid/ready handshake per requester, registered result with requester ID.
- The multi-cycle settle window allows the long ripple chain to close timing at high ANCHO.
- Sits between the operand sources and the result consumer in the arithmetic datapath.

Parameters:
- ANCHO, 64, operand width; passed to the internal Ripple_Carry.
- N_REQ, 4, number of requesters (2..8).
- SETTLE_CYC, 2, cycles the registered operands are held before the sum is captured (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request valid per requester.
- req_a  in  N_REQ*ANCHO  operand A; requester k occupies bits [k*ANCHO +: ANCHO].
- req_b  in  N_REQ*ANCHO  operand B, same packing as req_a.
- req_ready  out  N_REQ  one-hot accept pulse to the granted requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  ANCHO+1  {carry, sum}.
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns rsp_sum.

Behaviour:
- One clock domain, clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0.
  - rr_ptr=0, settle counter=0, operand registers=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - In the same cycle, req_ready[g]=1 (combinational from req_valid and rr_ptr, asserted only in IDLE); the transfer completes at that edge.
  - At that edge: latch req_a/req_b slice g into the operand registers, latch g into id_reg, rr_ptr <= (g+1) mod N_REQ, cnt <= SETTLE_CYC-1, go to CALC.
  - No req_valid: stay in IDLE, all req_ready=0.
- CALC:
  - The Ripple_Carry is fed only from the operand registers.
  - If cnt!=0, decrement cnt.
  - If cnt==0, register rsp_sum <= adder S and rsp_id <= id_reg, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready=1.
  - On the rsp_valid&rsp_ready edge: rsp_valid <= 0, go to IDLE.
  - No new grant is issued in RESP; a new grant is possible in the cycle after return to IDLE.
- Latency and throughput:
  - Grant edge to rsp_valid high = SETTLE_CYC+1 cycles.
  - Best-case throughput is one result per SETTLE_CYC+3 cycles (rsp_ready tied high).
- Arithmetic:
  - rsp_sum = A+B, zero-extended to ANCHO+1, with the carry in the MSB.
  - No overflow flag; unsigned only; carry-in fixed to 0.
- Boundary conditions:
  - Simultaneous requests: strict round-robin from rr_ptr. A requester still valid after its grant waits behind all other valid requesters.
  - rr_ptr wraps from N_REQ-1 to 0.
  - A requester that drops req_valid before its grant is never granted. No state is kept for ungranted requests.
  - req_a/req_b changes after the grant edge have no effect on the in-flight result.
  - rsp_ready high outside RESP is ignored.
  - rst in any state returns everything to reset values on the next edge. An in-flight result is discarded with no rsp_valid pulse.

Optional Feature:
- Macro: ADDER_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt [15:0].
  - Increments on every grant edge and saturates at 16'hFFFF.
  - Resets to 0 on rst.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then idle with all req_valid=0 for 10 cycles -> req_ready=0, rsp_valid=0, rsp_sum=0 throughout.
- Single request (ANCHO=64, SETTLE_CYC=2): req 1 sends A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> req_ready[1] pulses one cycle. Three cycles later rsp_valid=1, rsp_sum=65'h1_0000_0000_0000_0000, rsp_id=1.
- All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each grant is SETTLE_CYC+3=5 cycles after the previous one.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid with A=5, B=7 -> rsp_sum=12 and rsp_id stay stable, no req_ready pulse. rsp_ready=1 -> rsp_valid drops next edge.
- Operands changed to A=0, B=0 one cycle after the grant of A=100, B=23 -> rsp_sum=123. Assert rst during CALC -> no rsp_valid, rr_ptr=0, and the next grant with all req_valid high goes to requester 0.
- With ADDER_ARB_GRANT_CNT_EN: 3 completed transactions -> grant_cnt=3. Force 70000 grants (or preload via the bench) -> grant_cnt holds 16'hFFFF.
